// File: rtl/spike_event_collector.sv
// Spike onset detector feeding a timestamped address-event FIFO.
// First-word-fall-through head registers; saturating event/drop stats.
module spike_event_collector #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [31:0]              SpikeOut,
    input  logic [31:0]              SourceAddr,
    input  logic                     EvReady,
    input  logic                     ClrStat,
    output logic                     EvValid,
    output logic [31:0]              EvAddr,
    output logic [TS_W-1:0]          EvTime,
    output logic [$clog2(DEPTH):0]   Level,
    output logic [31:0]              EvCount,
    output logic [15:0]              DropCount,
    output logic                     Overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = TS_W + 32;

    logic [TS_W-1:0] time_q;
    logic            spike_prev_q;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [EW-1:0]   head_q, head_d;
    logic [31:0]     ev_cnt_q, ev_cnt_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic            ovf_q, ovf_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic spike_now, onset, pop, full, push, drop;
    logic [EW-1:0] new_ev;

    assign spike_now = |SpikeOut;
    assign onset     = spike_now & ~spike_prev_q;
    assign pop       = (level_q != '0) & EvReady;
    assign full      = (level_q == LW'(DEPTH));
    assign push      = onset & (~full | pop);
    assign drop      = onset & full & ~pop;
    assign new_ev    = {time_q, SourceAddr};

    // Next-state for pointers, occupancy, head view and statistics
    always_comb begin
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        head_d     = head_q;
        if (level_d != '0) begin
            // A write landing on the new read slot becomes the head directly
            if (push && (wptr_q == rptr_d))
                head_d = new_ev;
            else
                head_d = mem_q[rptr_d];
        end
        ev_cnt_d   = ev_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (onset && (ev_cnt_q != '1))
            ev_cnt_d = ev_cnt_q + 32'd1;
        if (drop && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + 16'd1;
        if (drop)
            ovf_d = 1'b1;
        if (ClrStat) begin
            ev_cnt_d   = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end
    end

    // Control, timebase and statistics registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            time_q       <= '0;
            spike_prev_q <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            head_q       <= '0;
            ev_cnt_q     <= '0;
            drop_cnt_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            time_q       <= time_q + 1'b1;
            spike_prev_q <= spike_now;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            head_q       <= head_d;
            ev_cnt_q     <= ev_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    // Event storage; contents need no reset since the head is separate
    always_ff @(posedge Clk) begin
        if (push)
            mem_q[wptr_q] <= new_ev;
    end

    assign EvValid   = (level_q != '0);
    assign EvAddr    = head_q[31:0];
    assign EvTime    = head_q[EW-1:32];
    assign Level     = level_q;
    assign EvCount   = ev_cnt_q;
    assign DropCount = drop_cnt_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_spike_event_collector.sv
// Bench for spike_event_collector: queue-based model plus scoreboard.
// Directed scenarios followed by randomized traffic.
module tb_spike_event_collector;

    localparam int DEPTH = 8;
    localparam int TS_W  = 16;

    logic              Clk = 0;
    logic              Rst = 0;
    logic [31:0]       SpikeOut = 0;
    logic [31:0]       SourceAddr = 0;
    logic              EvReady = 0;
    logic              ClrStat = 0;
    logic              EvValid;
    logic [31:0]       EvAddr;
    logic [TS_W-1:0]   EvTime;
    logic [3:0]        Level;
    logic [31:0]       EvCount;
    logic [15:0]       DropCount;
    logic              Overflow;

    spike_event_collector #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .Clk(Clk), .Rst(Rst), .SpikeOut(SpikeOut),
        .SourceAddr(SourceAddr), .EvReady(EvReady),
        .ClrStat(ClrStat), .EvValid(EvValid), .EvAddr(EvAddr),
        .EvTime(EvTime), .Level(Level), .EvCount(EvCount),
        .DropCount(DropCount), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: occupancy count, time, stats; scoreboard queue
    typedef struct packed { logic [15:0] t; logic [31:0] a; } ev_t;
    ev_t         sb_q[$];
    int          m_lvl = 0;
    int          m_time = 0;
    bit          m_prev = 0;
    longint      m_evc = 0;
    int          m_drop = 0;
    bit          m_ovf = 0;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_lvl = 0; m_time = 0; m_prev = 0;
            m_evc = 0; m_drop = 0; m_ovf = 0;
            sb_q.delete();
        end else begin
            bit spk, pop, on;
            spk = (SpikeOut != 0);
            on  = spk && !m_prev;
            pop = (m_lvl > 0) && EvReady;
            if (pop) m_lvl--;
            if (on) begin
                if (m_evc < 64'hFFFF_FFFF) m_evc++;
                if (m_lvl == DEPTH) begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1;
                end else begin
                    sb_q.push_back('{t: 16'(m_time), a: SourceAddr});
                    m_lvl++;
                end
            end
            if (ClrStat) begin
                m_evc = 0; m_drop = 0; m_ovf = 0;
            end
            m_prev = spk;
            m_time = (m_time + 1) % 65536;
        end
    end

    // Monitor: checks outputs mid-cycle, retires events on handshakes
    ev_t last_hd = '0;
    always @(negedge Clk) begin
        if (!Rst) begin
            last_hd = '0;
        end else begin
            chk("level", 64'(Level), 64'(m_lvl));
            chk("valid", 64'(EvValid), 64'(m_lvl != 0));
            chk("evcount", 64'(EvCount), 64'(m_evc));
            chk("dropcount", 64'(DropCount), 64'(m_drop));
            chk("overflow", 64'(Overflow), 64'(m_ovf));
            if (EvValid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 64'(1), 64'(0));
                end else begin
                    chk("head_addr", 64'(EvAddr), 64'(sb_q[0].a));
                    chk("head_time", 64'(EvTime), 64'(sb_q[0].t));
                    if (EvReady) last_hd = sb_q.pop_front();
                end
            end else begin
                chk("hold_addr", 64'(EvAddr), 64'(last_hd.a));
                chk("hold_time", 64'(EvTime), 64'(last_hd.t));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(logic [31:0] s, logic [31:0] a,
                         logic r, logic c);
        SpikeOut = s; SourceAddr = a; EvReady = r; ClrStat = c;
    endtask

    task automatic drain();
        drive(0, 0, 1, 0);
        for (int i = 0; i < 2 * DEPTH + 2; i++) tick();
    endtask

    int max_lvl;

    initial begin
        // Reset held with spike asserted
        drive(1, 32'h77, 1, 0);
        tick(); tick();
        chk("rst_valid", 64'(EvValid), 0);
        chk("rst_addr", 64'(EvAddr), 0);
        chk("rst_time", 64'(EvTime), 0);
        chk("rst_level", 64'(Level), 0);
        chk("rst_cnt", 64'(EvCount), 0);
        EvReady = 0;
        Rst = 1;
        tick();
        chk("rel_level", 64'(Level), 1);
        chk("rel_time", 64'(EvTime), 0);
        chk("rel_addr", 64'(EvAddr), 64'h77);
        drain();

        // Alternating spikes with consumer ready
        max_lvl = 0;
        for (int i = 0; i < 8; i++) begin
            drive((i % 2 == 0) ? 1 : 0, 5, 1, 0);
            tick();
            if (Level > max_lvl) max_lvl = Level;
        end
        chk("alt_maxlvl", 64'(max_lvl), 1);
        drain();

        // Held spike yields a single event
        drive(0, 0, 0, 1); tick();
        for (int i = 0; i < 6; i++) begin
            drive(32'h8000_0000, 9, 0, 0); tick();
        end
        chk("held_cnt", 64'(EvCount), 1);
        chk("held_lvl", 64'(Level), 1);
        drain();

        // Overflow: ten onsets into eight slots
        drive(0, 0, 0, 1); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h100 + i, 0, 0); tick();
            drive(0, 0, 0, 0); tick();
        end
        chk("ovf_level", 64'(Level), 8);
        chk("ovf_drop", 64'(DropCount), 2);
        chk("ovf_flag", 64'(Overflow), 1);
        chk("ovf_head", 64'(EvAddr), 64'h100);
        drain();

        // Full plus coincident pop, then clear against a drop
        drive(0, 0, 0, 1); tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h200 + i, 0, 0); tick();
            drive(0, 0, 0, 0); tick();
        end
        drive(1, 32'h2FF, 1, 0); tick();
        chk("fp_level", 64'(Level), 8);
        chk("fp_drop", 64'(DropCount), 0);
        drive(0, 0, 0, 0); tick();
        drive(1, 32'h3FF, 0, 1); tick();
        chk("clr_cnt", 64'(EvCount), 0);
        chk("clr_drop", 64'(DropCount), 0);
        chk("clr_ovf", 64'(Overflow), 0);
        drain();

        // Timestamp wrap: events at 65534 and 3
        drive(0, 0, 0, 0);
        while (m_time != 65534) tick();
        drive(1, 32'hA, 0, 0); tick();
        drive(0, 0, 0, 0);
        while (m_time != 3) tick();
        drive(1, 32'hB, 0, 0); tick();
        drive(0, 0, 0, 0); tick();
        chk("wrap_t0", 64'(EvTime), 65534);
        drive(0, 0, 1, 0); tick();
        chk("wrap_t1", 64'(EvTime), 3);
        drain();

        // Reset in the middle of a burst
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h400 + i, 0, 0); tick();
            drive(0, 0, 0, 0); tick();
        end
        chk("burst_lvl", 64'(Level), 4);
        #2 Rst = 0;
        #1;
        chk("async_lvl", 64'(Level), 0);
        chk("async_valid", 64'(EvValid), 0);
        chk("async_addr", 64'(EvAddr), 0);
        tick();
        Rst = 1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 2) == 0) ? 0 : $urandom,
                  $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 60) == 0);
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
